// File: rtl/uart_pkg.sv
// Shared definitions for the UART GPIO master: FSM encodings, frame constants
// and the helpers that size the bit-timing counters.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_START,
    ST_TX_DATA,
    ST_TX_STOP,
    ST_WAIT
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Width of a down-counter that holds 0 .. n-1.
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Free-running 8N1 receiver: 2-flop synchronizer, glitch-rejecting start
// detection and mid-bit sampling of data and stop bits.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rx_busy,
  output logic       rx_start,
  output logic       rx_done,
  output logic [7:0] rx_byte,
  output logic       rx_stop_bit
);

  localparam int CW = ctr_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign fall = prev_q & ~sync2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rx_start = 1'b0;
    rx_done  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (fall) begin
          state_d  = RX_START;
          cnt_d    = HALF_LOAD;
          rx_start = 1'b1;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // A line already back high at mid start bit was only a glitch.
          if (sync2_q != START_BIT) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          rx_done = 1'b1;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_busy     = (state_q != RX_IDLE);
  assign rx_byte     = shift_q;
  assign rx_stop_bit = sync2_q;

endmodule

// File: rtl/uart_gpio_master.sv
// Host-side initiator for the UART GPIO bridge: sends one command byte as 8N1
// and reports the bridge's echo byte or a timeout as a one-cycle pulse.
module uart_gpio_master
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_frame_err,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       TxD,
  input  logic       RxD
);

  localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW        = ctr_width(CPB);
  localparam int TMO_LIMIT = TIMEOUT_BITS * CPB;
  localparam int TW        = $clog2(TMO_LIMIT + 1);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CPB - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LIMIT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          ready_q, ready_d;
  logic          armed_q, armed_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_ferr_q, rsp_ferr_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  logic       rx_busy, rx_start, rx_done, rx_stop_bit;
  logic [7:0] rx_byte;
  logic       in_window, finishing, arm_ok, rx_fire, tmo_run, tmo_hit;

  uart_rx_core #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rxd        (RxD),
    .rx_busy    (rx_busy),
    .rx_start   (rx_start),
    .rx_done    (rx_done),
    .rx_byte    (rx_byte),
    .rx_stop_bit(rx_stop_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      txd_q         <= 1'b1;
      ready_q       <= 1'b1;
      armed_q       <= 1'b0;
      tmo_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_ferr_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      txd_q         <= txd_d;
      ready_q       <= ready_d;
      armed_q       <= armed_d;
      tmo_q         <= tmo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_ferr_q    <= rsp_ferr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // The response window opens with our stop bit; the pulse cycle closes it.
  always_comb begin
    in_window = (state_q == ST_TX_STOP) || (state_q == ST_WAIT);
    finishing = rsp_valid_q || rsp_timeout_q;
    arm_ok    = in_window && !finishing;
    rx_fire   = rx_done && armed_q;
    tmo_run   = in_window && !finishing && !(armed_q && rx_busy);
    tmo_hit   = tmo_run && (tmo_q == TMO_LAST);
  end

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    txd_d         = txd_q;
    armed_d       = armed_q;
    tmo_d         = tmo_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_ferr_d    = rsp_ferr_q;
    rsp_timeout_d = 1'b0;

    if (tmo_run) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = ST_TX_START;
          shift_d = req_data;
          txd_d   = START_BIT;
          baud_d  = BIT_LOAD;
        end
      end
      ST_TX_START: begin
        if (baud_q == '0) begin
          state_d = ST_TX_DATA;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          baud_d  = BIT_LOAD;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_TX_DATA: begin
        if (baud_q == '0) begin
          baud_d = BIT_LOAD;
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_TX_STOP;
            txd_d   = STOP_BIT;
            tmo_d   = '0;
          end else begin
            bit_d   = bit_q + 1'b1;
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_TX_STOP: begin
        if (baud_q == '0) begin
          state_d = ST_WAIT;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (finishing) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completing response beats a timeout landing on the same cycle.
    if (rx_fire) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rx_byte;
      rsp_ferr_d  = (rx_stop_bit != STOP_BIT);
    end else if (tmo_hit) begin
      rsp_timeout_d = 1'b1;
    end

    if (rx_start) begin
      armed_d = arm_ok;
    end else if (!rx_busy || rx_fire || (state_q == ST_IDLE)) begin
      armed_d = 1'b0;
    end
  end

  assign ready_d       = (state_d == ST_IDLE);
  assign req_ready     = ready_q;
  assign busy          = !ready_q;
  assign TxD           = txd_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_frame_err = rsp_ferr_q;
  assign rsp_timeout   = rsp_timeout_q;

endmodule

// File: tb/tb_uart_gpio_master.sv
// Directed and randomized transactions against a line-level model of the
// bridge: every outcome is predicted from frame timing arithmetic.
module tb_uart_gpio_master;

  localparam int C       = 10;               // clocks per bit at 1 MHz / 100 kbaud
  localparam int LOOP    = 380;              // cycles observed per transaction
  localparam int STOP_AT = 9 * C;            // first cycle of our stop bit
  localparam int TMO_IDX = STOP_AT + 16 * C; // timeout pulse cycle
  localparam int RSP_LAT = 2 + (19 * C) / 2 + 1;
  localparam int M_TMO = 0, M_RSP = 1, M_ANY = 2;
  localparam logic [7:0] GPIN = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_frame_err;
  logic       rsp_timeout;
  logic       busy;
  logic       TxD;
  logic       RxD;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_rsp;
  logic rxw [0:LOOP-1];
  logic txo [0:LOOP-1];
  logic rdo [0:LOOP-1];

  always #5 clk = ~clk;

  uart_gpio_master #(
    .CLK_FREQ    (1_000_000),
    .BAUD        (100_000),
    .TIMEOUT_BITS(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_frame_err(rsp_frame_err),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .TxD          (TxD),
    .RxD          (RxD)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Paint one 8N1 frame onto the RxD waveform starting at cycle index 'at'.
  task automatic paint_byte(input int at, input logic [7:0] b, input bit stop_low);
    logic v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) v = 1'b0;
      else if (k == 9) v = !stop_low;
      else v = b[k-1];
      for (int j = 0; j < C; j++)
        if (at + k * C + j < LOOP) rxw[at + k * C + j] = v;
    end
  endtask

  task automatic run_txn(input logic [7:0] cmd, input int rsp_at, input logic [7:0] rsp_byte,
                         input bit stop_low, input int mode, input bit bridge,
                         input int glitch_at, input int stray_at, input int busy_at,
                         input int rst_at);
    int v_cnt, t_cnt, v_idx, t_idx, p;
    logic [7:0] v_data, gpout, exp_byte;
    logic v_ferr, quiet;
    logic [1:0] busy5;
    logic [9:0] fr_obs, fr_exp;
    v_cnt = 0; t_cnt = 0; v_idx = -1; t_idx = -1;
    v_data = '0; v_ferr = 1'b0; gpout = '0; busy5 = '0;
    for (int i = 0; i < LOOP; i++) rxw[i] = 1'b1;
    if (!bridge && rsp_at >= 0) paint_byte(rsp_at, rsp_byte, stop_low);
    if (glitch_at >= 0) for (int j = 0; j < 3; j++) rxw[glitch_at + j] = 1'b0;
    if (stray_at >= 0) paint_byte(stray_at, 8'h55, 1'b0);
    exp_byte = bridge ? GPIN : rsp_byte;

    check("ready_pre", 32'(req_ready), 32'd1);
    req_data  = cmd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;

    for (int i = 0; i < LOOP; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_txd", 32'(TxD), 32'd1);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", {22'd0, rsp_valid, rsp_timeout, rsp_data}, 32'd0);
        RxD = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hold", {30'd0, TxD, req_ready}, 32'd3);
        rst = 1'b0;
        last_rsp = 8'h00;
        @(negedge clk);
        return;
      end
      txo[i] = TxD;
      rdo[i] = req_ready;
      if (i == 5) busy5 = {busy, req_ready};
      if (rsp_valid === 1'b1) begin
        v_cnt++; v_idx = i; v_data = rsp_data; v_ferr = rsp_frame_err;
      end
      if (rsp_timeout === 1'b1) begin
        t_cnt++; t_idx = i;
      end
      if (bridge && i == STOP_AT + 1) begin
        for (int k = 0; k < 8; k++) gpout[k] = txo[(k + 1) * C + C / 2];
        paint_byte(rsp_at, GPIN, 1'b0);
      end
      RxD       = rxw[i];
      req_valid = (busy_at >= 0) && (i >= busy_at) && (i < busy_at + 20);
      req_data  = req_valid ? 8'h12 : cmd;
      @(negedge clk);
    end
    RxD = 1'b1;
    req_valid = 1'b0;

    check("txd_fall", 32'(txo[0]), 32'd0);
    check("busy_flag", 32'(busy5), 32'd2);
    for (int k = 0; k < 10; k++) fr_obs[k] = txo[k * C + C / 2];
    fr_exp = {1'b1, cmd, 1'b0};
    check("tx_frame", 32'(fr_obs), 32'(fr_exp));
    if (bridge) check("gpout", 32'(gpout), 32'(cmd));

    case (mode)
      M_RSP: begin
        check("rsp_count", v_cnt, 1);
        check("tmo_count", t_cnt, 0);
        check("rsp_time", v_idx, rsp_at + RSP_LAT);
        check("rsp_data", 32'(v_data), 32'(exp_byte));
        check("rsp_ferr", 32'(v_ferr), 32'(stop_low));
      end
      M_TMO: begin
        check("tmo_count", t_cnt, 1);
        check("rsp_count", v_cnt, 0);
        check("tmo_time", t_idx, TMO_IDX);
        check("data_hold", 32'(rsp_data), 32'(last_rsp));
      end
      default: begin
        check("one_pulse", v_cnt + t_cnt, 1);
        if (v_cnt == 1) check("race_data", 32'(v_data), 32'(exp_byte));
      end
    endcase
    if (v_cnt == 1) last_rsp = exp_byte;

    p = (v_cnt > 0) ? v_idx : t_idx;
    if (p >= 0 && p < LOOP - 1) begin
      check("ready_rise", {30'd0, rdo[p], rdo[p+1]}, 32'd1);
      quiet = 1'b1;
      for (int i = p; i < LOOP; i++) if (txo[i] !== 1'b1) quiet = 1'b0;
      check("tx_quiet", 32'(quiet), 32'd1);
    end
    check("idle_end", 32'(req_ready), 32'd1);
    $display("txn cmd=%02h mode=%0d rsp_at=%0d valid=%0d@%0d timeout=%0d@%0d data=%02h",
             cmd, mode, rsp_at, v_cnt, v_idx, t_cnt, t_idx, v_data);
  endtask

  initial begin
    logic [7:0] rc, rb;
    int ra;
    bit rs;
    rst = 1'b1; req_valid = 1'b0; req_data = '0; RxD = 1'b1;
    last_rsp = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(TxD), 32'd1);
    check("reset_ready", {30'd0, req_ready, busy}, 32'd2);
    check("reset_rsp", {21'd0, rsp_valid, rsp_frame_err, rsp_timeout, rsp_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // cmd, rsp_at, rsp_byte, stop_low, mode, bridge, glitch, stray, busy_req, rst_at
    run_txn(8'hA5, STOP_AT + 5, 8'h3C, 1'b0, M_RSP, 1'b0, -1, -1, -1, -1);
    run_txn(8'h00, -1, 8'h00, 1'b0, M_TMO, 1'b0, -1, -1, -1, -1);
    run_txn(8'h96, 100, 8'h7E, 1'b1, M_RSP, 1'b0, -1, -1, -1, -1);
    run_txn(8'h3B, 140, 8'h81, 1'b0, M_RSP, 1'b0, 110, -1, -1, -1);
    run_txn(8'h4D, -1, 8'h00, 1'b0, M_TMO, 1'b0, -1, 20, -1, -1);
    run_txn(8'h34, 120, 8'h99, 1'b0, M_RSP, 1'b0, -1, -1, 20, -1);
    run_txn(8'h61, 240, 8'hE7, 1'b0, M_RSP, 1'b0, -1, -1, -1, -1);
    for (int s = TMO_IDX - 4; s <= TMO_IDX - 2; s++)
      run_txn(8'h61, s, 8'hE7, 1'b0, M_ANY, 1'b0, -1, -1, -1, -1);
    run_txn(8'h61, TMO_IDX + 2, 8'hE7, 1'b0, M_TMO, 1'b0, -1, -1, -1, -1);

    for (int n = 0; n < 6; n++) begin
      rc = 8'($urandom);
      rb = 8'($urandom);
      ra = $urandom_range(STOP_AT, 180);
      rs = ($urandom_range(0, 3) == 0);
      run_txn(rc, ra, rb, rs, M_RSP, 1'b0, -1, -1, -1, -1);
    end

    run_txn(8'hF0, -1, 8'h00, 1'b0, M_TMO, 1'b0, -1, -1, -1, 5 * C + 4);
    run_txn(8'hC3, STOP_AT + 5, 8'h00, 1'b0, M_RSP, 1'b1, -1, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
